// File: rtl/rate_div_pkg.sv
// Shared constants and helpers for the multi-rate clock-enable divider.
// div_for() converts a target square-wave frequency into a divisor value.
package rate_div_pkg;

    localparam int unsigned CLK_SYS_HZ = 50_000_000;
    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_CNT_W  = 21;
    localparam int unsigned DEF_DIV    = 1_666_666;

    // Divisor giving a 50% square wave of out_hz on clkout.
    function automatic int unsigned div_for(input int unsigned clk_hz,
                                            input int unsigned out_hz);
        return clk_hz / (2 * out_hz) - 1;
    endfunction

endpackage

// File: rtl/rate_div_channel.sv
// One divider channel: divisor register plus down-counter producing a
// one-cycle tick every div+1 cycles and a square wave toggling on each tick.
module rate_div_channel
    import rate_div_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] div_value,
    input  logic             sync,
    output logic             tick,
    output logic             clkout
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    always_comb begin
        // A load coinciding with a reload or sync takes effect immediately.
        div_d  = load ? div_value : div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        clk_d  = clk_q;
        if (sync) begin
            cnt_d = div_d;
            clk_d = 1'b0;
        end else if (enable) begin
            if (cnt_q == '0) begin
                cnt_d  = div_d;
                tick_d = 1'b1;
                clk_d  = ~clk_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            div_q  <= DIV_RST;
            cnt_q  <= DIV_RST;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick   = tick_q;
    assign clkout = clk_q;

endmodule

// File: rtl/multi_rate_divider.sv
// NUM_CH independent clock-enable dividers sharing reset and a phase-realign
// strobe. clkout is data only; downstream logic should qualify on tick.
module multi_rate_divider
    import rate_div_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] div_value,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       clkout
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        rate_div_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clkin    (clkin),
            .reset    (reset),
            .enable   (enable[k]),
            .load     (load[k]),
            .div_value(div_value[k*CNT_W +: CNT_W]),
            .sync     (sync),
            .tick     (tick[k]),
            .clkout   (clkout[k])
        );
    end

endmodule
